// File: rtl/router_pkg.sv
// router_pkg: shared widths, header length field position and tagged FIFO entry type.
package router_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int LEN_MSB = DATA_W_DEF - 1;
  localparam int LEN_LSB = 2;
  typedef struct packed {
    logic                  hdr;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;
endpackage

// File: rtl/router_fifo_mem.sv
// router_fifo_mem: DEPTH x W register array, one sync write port, one registered read port.
module router_fifo_mem #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_rst,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end
  // Only the read register is cleared; the array keeps its contents.
  always_ff @(posedge clk) begin
    if (i_rst) o_rdata <= '0;
    else if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/router_pkt_fifo.sv
// router_pkt_fifo: tagged router output FIFO with read-side packet tracking and flush.
// Optional watchdog flush enabled by defining ROUTER_PKT_FIFO_TIMEOUT_EN.
module router_pkt_fifo
  import router_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int TIMEOUT   = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     soft_rst,
  input  logic                     write_enb,
  input  logic                     read_enb,
  input  logic                     lfd_state,
  input  logic [DATA_W-1:0]        data_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_out_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     pkt_active,
  output logic                     pkt_end,
  output logic                     pkt_err,
  output logic                     timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2((2 ** (DATA_W - 2)) + 1);
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_cnt;
  logic [PW-1:0]       r_pkt_cnt, w_pkt_cnt;
  logic                r_valid, w_we, w_re, w_flush, w_wd_hit, w_hdr;
  logic [DATA_W:0]     w_rdata;
  logic [DATA_W-3:0]   w_len;
  assign full        = r_cnt == CW'(DEPTH);
  assign empty       = r_cnt == '0;
  assign almost_full = r_cnt >= CW'(DEPTH - AF_MARGIN);
  assign count       = r_cnt;
  assign w_we        = write_enb && !full;
  assign w_re        = read_enb && !empty;
  assign w_flush     = rst || soft_rst || w_wd_hit;
  router_fifo_mem #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .i_rst   (w_flush),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata ({lfd_state, data_in}),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );
  assign {w_hdr, data_out} = w_rdata;
  assign w_len             = data_out[DATA_W-1:LEN_LSB];
  assign data_out_valid    = r_valid;
  // Packet state is advanced by the word currently presented, so all pulses line up with data_out_valid.
  always_comb begin
    w_pkt_cnt = !r_valid ? r_pkt_cnt :
                w_hdr ? PW'(w_len) + PW'(1) :
                r_pkt_cnt != '0 ? r_pkt_cnt - PW'(1) : '0;
  end
  assign pkt_active = w_pkt_cnt != '0;
  assign pkt_end    = r_valid && !w_hdr && r_pkt_cnt == PW'(1);
  assign pkt_err    = r_valid && w_hdr && r_pkt_cnt != '0;
  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_wr_ptr  <= r_wr_ptr + AW'(w_we);
      r_rd_ptr  <= r_rd_ptr + AW'(w_re);
      r_cnt     <= r_cnt + CW'(w_we) - CW'(w_re);
      r_valid   <= w_re;
      r_pkt_cnt <= w_pkt_cnt;
    end
  end
`ifdef ROUTER_PKT_FIFO_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wd;
  logic          r_timeout;
  assign w_wd_hit = r_wd == TW'(TIMEOUT);
  assign timeout  = r_timeout;
  always_ff @(posedge clk) begin
    r_timeout <= w_wd_hit && !rst && !soft_rst;
    if (w_flush || empty || w_re) r_wd <= '0;
    else r_wd <= r_wd + TW'(1);
  end
`else
  assign w_wd_hit = 1'b0;
  assign timeout  = TIMEOUT < 0;
`endif
endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb_router_pkt_fifo: randomized + directed scoreboard bench against a queue-based reference model.
module tb_router_pkt_fifo;
  logic       clk = 1'b0;
  logic       rst, soft_rst, write_enb, read_enb, lfd_state;
  logic [7:0] data_in, data_out;
  logic       data_out_valid, full, empty, almost_full;
  logic [4:0] count;
  logic       pkt_active, pkt_end, pkt_err, timeout;
  router_pkt_fifo dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .write_enb(write_enb), .read_enb(read_enb),
    .lfd_state(lfd_state), .data_in(data_in), .data_out(data_out), .data_out_valid(data_out_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count), .pkt_active(pkt_active),
    .pkt_end(pkt_end), .pkt_err(pkt_err), .timeout(timeout)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic h; logic [7:0] d; } ent_t;
  typedef struct packed { logic [7:0] d; logic e; logic x; } exp_t;
  ent_t       mq[$];
  exp_t       eq[$];
  exp_t       got;
  int         rem = 0, wd = 0, checks = 0, errors = 0;
  logic [7:0] m_dout = '0;
  logic       m_valid = 1'b0, m_to = 1'b0;
  bit         live = 1'b0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input bit r, input bit s, input bit we, input bit re, input bit lfd, input logic [7:0] d);
    int   n;
    bit   ar, aw, hit;
    ent_t e;
    exp_t x;
    rst = r; soft_rst = s; write_enb = we; read_enb = re; lfd_state = lfd; data_in = d;
    n  = mq.size();
    ar = re && n > 0;
    aw = we && n < 16;
    hit = 1'b0;
`ifdef ROUTER_PKT_FIFO_TIMEOUT_EN
    hit = wd == 30;
`endif
    @(posedge clk);
    if (r || s || hit) begin
      mq.delete();
      rem = 0; wd = 0; m_dout = '0; m_valid = 1'b0;
      m_to = hit && !r && !s;
    end else begin
      m_to = 1'b0;
      m_valid = ar;
      wd = (n == 0 || ar) ? 0 : wd + 1;
      if (ar) begin
        e = mq.pop_front();
        x.d = e.d;
        x.x = e.h && rem != 0;
        x.e = 1'b0;
        if (e.h) rem = int'(e.d[7:2]) + 1;
        else if (rem > 0) begin
          rem--;
          x.e = rem == 0;
        end
        eq.push_back(x);
        m_dout = e.d;
      end
      if (aw) mq.push_back({lfd, d});
    end
    live = 1'b1;
    @(negedge clk);
  endtask
  task automatic wr(input logic [7:0] d, input bit lfd); cyc(0, 0, 1, 0, lfd, d); endtask
  task automatic rd(); cyc(0, 0, 0, 1, 0, 8'h00); endtask
  task automatic idle(); cyc(0, 0, 0, 0, 0, 8'h00); endtask
  always @(negedge clk) begin
    if (live) begin
      chk("count", count, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("full", full, mq.size() == 16);
      chk("almost_full", almost_full, mq.size() >= 14);
      chk("pkt_active", pkt_active, rem != 0);
      chk("data_out_valid", data_out_valid, m_valid);
      chk("data_out", data_out, m_dout);
      chk("timeout", timeout, m_to);
      if (data_out_valid) begin
        chk("pop_pending", eq.size() != 0, 1);
        if (eq.size() != 0) begin
          got = eq.pop_front();
          chk("pop_data", data_out, got.d);
          chk("pkt_end", pkt_end, got.e);
          chk("pkt_err", pkt_err, got.x);
        end
      end else begin
        chk("pkt_end_idle", pkt_end, 0);
        chk("pkt_err_idle", pkt_err, 0);
      end
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 8'hEE);
    // single packet: header len=3, three payload bytes, parity
    wr(8'h0C, 1); wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0); wr(8'h5A, 0);
    repeat (5) rd();
    idle();
    // fill past full, drain with pointer wrap
    for (int i = 0; i < 16; i++) wr(8'(i), 0);
    wr(8'hFF, 0);
    repeat (16) rd();
    idle();
    // simultaneous read/write at full and at empty
    for (int i = 0; i < 16; i++) wr(8'(i + 8'h40), 0);
    cyc(0, 0, 1, 1, 0, 8'hAB);
    repeat (15) rd();
    cyc(0, 0, 1, 1, 0, 8'hCD);
    rd(); idle();
    // header interrupted by another header
    wr(8'h08, 1); wr(8'h01, 0); wr(8'h08, 1); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0); wr(8'h77, 0);
    repeat (7) rd();
    idle();
    // soft reset with a concurrent write
    wr(8'h10, 0); wr(8'h20, 0); wr(8'h30, 0);
    rd();
    cyc(0, 1, 1, 0, 0, 8'h99);
    rd(); idle();
    // randomized traffic: write-heavy then read-heavy phases
    for (int p = 0; p < 3000; p++) begin
      int wp;
      wp = (p % 600) < 300 ? 3 : 1;
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
          $urandom_range(0, 3) < wp, $urandom_range(0, 3) >= wp,
          $urandom_range(0, 5) == 0, 8'($urandom));
    end
    cyc(1, 0, 0, 0, 0, 0);
`ifdef ROUTER_PKT_FIFO_TIMEOUT_EN
    wr(8'h42, 0);
    repeat (34) idle();
    wr(8'h43, 0);
    repeat (19) idle();
    rd();
    repeat (34) idle();
`endif
    repeat (2) idle();
    chk("scoreboard_drained", eq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_pkt_fifo.md
Name: router_pkt_fifo

Overview:
- Parametrised successor to the router output FIFO in the 1x3 router; one instance per output port, between the register/FSM stage and the port's read interface.
- Stores a 1-bit header tag alongside each data word.
- Tracks packet boundaries on the read side using the length field in the header.
- Supports a soft-reset flush and reports occupancy.

Parameters:
- DATA_W, 8, data word width; header length field is data[DATA_W-1:2].
- DEPTH, 16, number of entries; must be a power of 2, minimum 4.
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH-AF_MARGIN.
- TIMEOUT, 30, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- soft_rst  in  1  synchronous flush request from the router FSM; same effect as rst.
- write_enb  in  1  write request.
- read_enb  in  1  read request.
- lfd_state  in  1  marks the current write as a header byte; stored as the tag bit.
- data_in  in  DATA_W  write data.
- data_out  out  DATA_W  registered read data.
- data_out_valid  out  1  data_out holds a word popped in the previous cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  see AF_MARGIN.
- count  out  $clog2(DEPTH)+1  occupancy.
- pkt_active  out  1  mid-packet on the read side (pkt_cnt != 0).
- pkt_end  out  1  one-cycle pulse, aligned with data_out_valid, when the last byte of a packet (the parity byte) is presented.
- pkt_err  out  1  one-cycle pulse when a header is popped while pkt_cnt != 0.
- timeout  out  1  one-cycle pulse on a watchdog flush; tied 0 without the macro.

Behaviour:
- Reset (rst or soft_rst high at a rising edge):
  - pointers, count, pkt_cnt and data_out go to 0;
  - data_out_valid, pkt_end, pkt_err and timeout go to 0;
  - empty=1, full=0, almost_full=0;
  - reset overrides any same-cycle read or write; memory contents are not cleared.
- Write: accepted iff write_enb && !full. Stores {lfd_state, data_in} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Read: accepted iff read_enb && !empty.
  - The entry at rd_ptr appears on data_out the next cycle, with data_out_valid=1.
  - When no read is accepted, data_out holds its value and data_out_valid=0.
- Simultaneous accepted read and write: count is unchanged. When full, a same-cycle write is dropped even if a read is accepted. When empty, a read is ignored and a same-cycle write is accepted.
- Read-side packet counter (pkt_cnt, $clog2 width sufficient for 2^(DATA_W-2)+1):
  - Popping a tagged word loads pkt_cnt = len+1, where len = data[DATA_W-1:2]; the +1 counts the parity byte. If pkt_cnt was already nonzero, pkt_err is also pulsed.
  - Popping an untagged word with pkt_cnt>0 decrements it. The transition 1->0 raises pkt_end, aligned with data_out_valid.
  - Popping an untagged word with pkt_cnt==0 leaves pkt_cnt at 0 with no error (stray data).
  - len=0 header: pkt_cnt=1; the next pop ends the packet.
- Flags and count are registered and reflect the state after the current edge.

Optional Feature:
- Macro: ROUTER_PKT_FIFO_TIMEOUT_EN.
- With the macro: a watchdog counter increments each cycle that !empty && no read is accepted, and clears on an accepted read or when empty.
  - When it reaches TIMEOUT, the next edge flushes the FIFO exactly as soft_rst does and pulses timeout.
  - The watchdog clears on rst and soft_rst.
- Without the macro: no watchdog logic is built and timeout is constant 0.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W default;
  - header length field position constants (LEN_MSB=DATA_W-1, LEN_LSB=2);
  - a typedef for the tagged entry {hdr, data}.
- One sub-module, router_fifo_mem: a DEPTH x (DATA_W+1) register array with one synchronous write port and one synchronous read port, with no reset on the array.
- Pointers, flags, packet counter and watchdog stay in router_pkt_fifo.

Test Plan:
- Reset then write header 0x0C (len=3, lfd=1) plus 0x11, 0x22, 0x33 and parity 0x5A, then 5 reads -> data_out 0C,11,22,33,5A on consecutive cycles; pkt_active=1 from the header pop until the 5A pop; pkt_end pulses with 5A; count returns to 0; empty=1.
- Write 16 words 0x00..0x0F -> full=1 at count=16, almost_full=1 from count=14; a 17th write of 0xFF is dropped; 16 reads return 00..0F in order, and the pointers wrap.
- With FIFO full, assert read_enb and write_enb together with data 0xAB -> 0xAB is dropped, count=15; with FIFO empty, both asserted with 0xCD -> count=1, data_out_valid=0, and the next read returns 0xCD.
- Header 0x08 (len=2) popped, then another header popped after one payload byte -> pkt_err pulses once; pkt_cnt reloads to 3.
- 3 words queued, assert soft_rst for one cycle with a concurrent write -> count=0, empty=1, the write is discarded, data_out=0.
- With ROUTER_PKT_FIFO_TIMEOUT_EN and TIMEOUT=30, write one word and never read -> timeout pulses and the FIFO is empty 31 cycles after the write; a read at cycle 20 instead clears the watchdog and no timeout occurs.
